// File: rtl/code_entry_tx_if.sv
// code_entry_tx_if: keypad-side request lines and security-side serial/status lines
interface code_entry_tx_if #(
  parameter int CODE_W = 4,
  parameter int TRY_W  = 2
);
  logic              S;
  logic              start;
  logic              panic;
  logic [CODE_W-1:0] code;
  logic              X;
  logic              busy;
  logic              done;
  logic [TRY_W-1:0]  tries;
  logic              lock_out;
  modport master (output S, start, panic, code, input X, busy, done, tries, lock_out);
  modport slave  (input S, start, panic, code, output X, busy, done, tries, lock_out);
endinterface

// File: rtl/code_entry_tx.sv
// code_entry_tx: serial code-entry transmitter with attempt lockout; CODE_ENTRY_PANIC_EN adds a panic frame
module code_entry_tx #(
  parameter int CODE_W  = 4,
  parameter int GAP_LEN = 2,
  parameter int MAX_TRY = 3,
  parameter int TRY_W   = 2
) (
  input logic            U,
  input logic            R,
  code_entry_tx_if.slave bus
);
  localparam int CNT_W = $clog2(CODE_W + GAP_LEN + 4);
  typedef enum logic [2:0] {IDLE, SEND, CONF, GAP, PANIC} state_t;
  state_t            state_q;
  logic [CODE_W-1:0] sh_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TRY_W-1:0]  tries_q;
  logic              x_q, busy_q, done_q, lock;
`ifdef CODE_ENTRY_PANIC_EN
  logic              pgap_q;
`endif
  assign lock         = tries_q == TRY_W'(MAX_TRY);
  assign bus.X        = x_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tries    = tries_q;
  assign bus.lock_out = lock;
  // Frame sequencer: SEND shifts the latched code MSB first, then confirm bit, guard gap, back to IDLE
  always_ff @(posedge U) begin
    done_q <= 1'b0;
    if (R || !bus.S) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CODE_ENTRY_PANIC_EN
      pgap_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef CODE_ENTRY_PANIC_EN
          if (bus.panic) begin
            state_q <= PANIC;
            x_q     <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else
`endif
          if (bus.start && !lock) begin
            state_q <= SEND;
            x_q     <= bus.code[CODE_W-1];
            sh_q    <= bus.code << 1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SEND: begin
          if (cnt_q == CNT_W'(CODE_W - 1)) begin
            state_q <= CONF;
            x_q     <= 1'b0;
          end else begin
            x_q   <= sh_q[CODE_W-1];
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CONF: begin
          state_q <= GAP;
          cnt_q   <= '0;
        end
        GAP: begin
          if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
`ifdef CODE_ENTRY_PANIC_EN
            pgap_q  <= 1'b0;
            if (!pgap_q) begin
              done_q  <= 1'b1;
              tries_q <= lock ? tries_q : tries_q + 1'b1;
            end
`else
            done_q  <= 1'b1;
            tries_q <= lock ? tries_q : tries_q + 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef CODE_ENTRY_PANIC_EN
        PANIC: begin
          if (cnt_q == CNT_W'(2)) begin
            state_q <= GAP;
            x_q     <= 1'b0;
            cnt_q   <= '0;
            pgap_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_code_entry_tx.sv
// tb_code_entry_tx: directed checks of code frames, latching, lockout, aborts and panic
module tb_code_entry_tx;
  logic U = 1'b0;
  logic R = 1'b1;
  int passed = 0;
  int total = 0;
  code_entry_tx_if #(.CODE_W(4), .TRY_W(2)) bus ();
  code_entry_tx #(.CODE_W(4), .GAP_LEN(2), .MAX_TRY(3), .TRY_W(2)) dut (.U(U), .R(R), .bus(bus));
  always #5 U = ~U;
  task automatic tick;
    @(posedge U);
    #1;
  endtask
  task automatic test_reset;
    logic [5:0] got;
    R = 1'b1; bus.S = 1'b0; bus.start = 1'b0; bus.panic = 1'b0; bus.code = 4'b0000;
    tick; tick;
    got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
    total++;
    if (got !== 6'b0) $display("FAIL reset: got %b want %b", got, 6'b0); else passed++;
    R = 1'b0; bus.S = 1'b1;
    tick;
  endtask
  task automatic test_basic;
    logic [3:0] cd;
    logic [5:0] got, e;
    cd = 4'b0100;
    bus.code = cd; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      e = {(c <= 4) ? cd[4-c] : 1'b0, c < 8, c == 8, (c == 8) ? 2'd1 : 2'd0, 1'b0};
      got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
      total++;
      if (got !== e) $display("FAIL basic cycle %0d: got %b want %b", c, got, e); else passed++;
      tick;
    end
  endtask
  task automatic test_latch;
    logic [3:0] cd;
    logic [5:0] got, e;
    cd = 4'b0100;
    bus.code = cd; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      e = {(c <= 4) ? cd[4-c] : 1'b0, c < 8, c == 8, (c == 8) ? 2'd2 : 2'd1, 1'b0};
      got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
      total++;
      if (got !== e) $display("FAIL latch cycle %0d: got %b want %b", c, got, e); else passed++;
      if (c == 2) bus.code = 4'b1111;
      tick;
    end
  endtask
  task automatic test_reset_mid;
    logic [5:0] got;
    bus.code = 4'b1011; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    R = 1'b1;
    tick;
    R = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
      total++;
      if (got !== 6'b0) $display("FAIL reset_mid cycle %0d: got %b want %b", c, got, 6'b0); else passed++;
      tick;
    end
  endtask
  task automatic test_lockout;
    logic [3:0] cd;
    logic [1:0] t;
    logic [5:0] got, e;
    int p;
    cd = 4'b1010;
    bus.code = cd; bus.start = 1'b1;
    tick;
    for (int c = 1; c <= 24; c++) begin
      p = (c - 1) % 8 + 1;
      t = (p == 8) ? 2'(c / 8) : 2'((c - 1) / 8);
      e = {(p <= 4) ? cd[4-p] : 1'b0, p < 8, p == 8, t, t == 2'd3};
      got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
      total++;
      if (got !== e) $display("FAIL lockout cycle %0d: got %b want %b", c, got, e); else passed++;
      tick;
    end
    for (int c = 25; c <= 32; c++) begin
      got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
      total++;
      if (got !== 6'b000111) $display("FAIL lockout_drop cycle %0d: got %b want %b", c, got, 6'b000111); else passed++;
      tick;
    end
    bus.start = 1'b0;
  endtask
  task automatic test_panic;
    logic [5:0] got, e;
    bus.panic = 1'b1; bus.start = 1'b1;
    tick;
    bus.panic = 1'b0; bus.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
`ifdef CODE_ENTRY_PANIC_EN
      e = {c <= 3, c <= 5, 1'b0, 2'd3, 1'b1};
`else
      e = 6'b000111;
`endif
      got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
      total++;
      if (got !== e) $display("FAIL panic cycle %0d: got %b want %b", c, got, e); else passed++;
      tick;
    end
  endtask
  task automatic test_clear;
    logic [5:0] got;
    bus.S = 1'b0;
    tick;
    bus.S = 1'b1;
    got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
    total++;
    if (got !== 6'b0) $display("FAIL clear: got %b want %b", got, 6'b0); else passed++;
    tick;
  endtask
  task automatic test_abort;
    logic [3:0] cd;
    logic [5:0] got, e;
    cd = 4'b1100;
    bus.code = cd; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      e = (c <= 3) ? {cd[4-c], 1'b1, 1'b0, 2'd0, 1'b0} : 6'b0;
      got = {bus.X, bus.busy, bus.done, bus.tries, bus.lock_out};
      total++;
      if (got !== e) $display("FAIL abort cycle %0d: got %b want %b", c, got, e); else passed++;
      bus.S = (c != 3);
      tick;
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_latch;
    test_reset_mid;
    test_lockout;
    test_panic;
    test_clear;
    test_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
